mips32_prog_loader: RTL and testbench

Byte-serial program loader that sits directly upstream of the mips32 core's unified memory. It accepts a framed byte stream (length header, big-endian 32-bit words, optional checksum), assembles words and writes them into consecutive memory locations starting at a fixed base address. It then releases the core to run. While loading, the core is held and the loader is the only memory writer.

---
 rtl/mips32_prog_loader.sv | 146 ++++++++++++++
 tb/tb_mips32_prog_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - byte-serial framed program loader for the mips32 unified memory
// Optional trailing XOR checksum: define MIPS32_LOADER_CHECKSUM_EN.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_run,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX_LEN = 32'((2 ** ADDR_W) - BASE_ADDR);

  state_t        state;
  logic [15:0]   len;
  logic [1:0]    byte_idx;
  logic [23:0]   shift;
`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  logic          xfer;
  logic [15:0]   len_next;
  logic [ADDR_W:0] wl_inc;

  assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHK);
  assign busy     = in_ready;
  assign core_run = done;
  assign xfer     = in_valid && in_ready;
  assign len_next = {len[15:8], in_data};
  assign wl_inc   = words_loaded + 1'b1;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            state        <= LEN_HI;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            chk          <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= in_data;
            // Oversized loads are rejected before any write so the address never wraps.
            if (32'(len_next) > MAX_LEN) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (len_next == 16'd0) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
            chk      <= chk ^ in_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= BASE + words_loaded[ADDR_W-1:0];
              mem_wdata    <= {shift, in_data};
              words_loaded <= wl_inc;
              if (32'(wl_inc) == 32'(len)) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= DONE;
                done  <= 1'b1;
`endif
              end
            end else begin
              shift <= {shift[15:0], in_data};
            end
          end
        end
        CHK: begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
          if (xfer) begin
            if (in_data == chk) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - directed self-checking bench for mips32_prog_loader
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_run;
  logic [10:0] words_loaded;

  mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk1(clk1), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
    .core_run(core_run), .words_loaded(words_loaded)
  );

  always #5 clk1 = ~clk1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int wr_n  = 0;
  logic [9:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  logic        wr_done [64];

  // Write log: sampled at the edge that ends each mem_we cycle.
  always @(posedge clk1) begin
    cyc = cyc + 1;
    if (mem_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_done[wr_n] = done;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  int s;
  int b;

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_core_run", core_run, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_words", words_loaded, 0);
    rst = 1'b0;
    tick();

`ifndef MIPS32_LOADER_CHECKSUM_EN
    // two words at full rate
    start(); s = cyc; b = wr_n;
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 1);
    send(8'h00); send(8'h02); send(8'h28); send(8'h01); send(8'h00); send(8'h0A);
    check("t1_we0", mem_we, 1);
    check("t1_addr0", mem_addr, 0);
    check("t1_data0", mem_wdata, 32'h2801000A);
    check("t1_words1", words_loaded, 1);
    check("t1_done_early", done, 0);
    send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
    check("t1_we1", mem_we, 1);
    check("t1_addr1", mem_addr, 1);
    check("t1_data1", mem_wdata, 32'hFC000000);
    check("t1_done", done, 1);
    check("t1_core_run", core_run, 1);
    check("t1_words2", words_loaded, 2);
    check("t1_in_ready_off", in_ready, 0);
    tick(); tick();
    check("t1_nwr", wr_n - b, 2);
    check("t1_cyc0", wr_cyc[b] - s, 7);
    check("t1_cyc1", wr_cyc[b+1] - s, 11);
    check("t1_wr_done", wr_done[b+1], 1);

    // same stream with a 3-cycle stall inside word 0
    start(); s = cyc; b = wr_n;
    send(8'h00); send(8'h02); send(8'h28); send(8'h01);
    tick(); check("t2_gap_we", mem_we, 0);
    tick(); tick();
    send(8'h00); send(8'h0A); send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
    check("t2_done", done, 1);
    tick(); tick();
    check("t2_nwr", wr_n - b, 2);
    check("t2_addr0", wr_addr[b], 0);
    check("t2_data0", wr_data[b], 32'h2801000A);
    check("t2_addr1", wr_addr[b+1], 1);
    check("t2_data1", wr_data[b+1], 32'hFC000000);
    check("t2_cyc0", wr_cyc[b] - s, 10);
    check("t2_cyc1", wr_cyc[b+1] - s, 14);

    // zero-length load
    start(); b = wr_n;
    send(8'h00); send(8'h00);
    check("t6_done", done, 1);
    check("t6_words", words_loaded, 0);
    check("t6_busy", busy, 0);
    tick();
    check("t6_nwr", wr_n - b, 0);
`else
    // checksum match
    start(); b = wr_n;
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    check("c1_we", mem_we, 1);
    check("c1_addr", mem_addr, 0);
    check("c1_data", mem_wdata, 32'h12345678);
    check("c1_done_early", done, 0);
    check("c1_in_ready", in_ready, 1);
    send(8'h08);
    check("c1_done", done, 1);
    check("c1_err", err, 0);

    // checksum mismatch
    start();
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h09);
    check("c2_err", err, 1);
    check("c2_done", done, 0);
    check("c2_core_run", core_run, 0);

    // zero-length needs a 0x00 checksum byte
    start();
    send(8'h00); send(8'h00);
    check("c3_busy", busy, 1);
    send(8'h00);
    check("c3_done", done, 1);
`endif

    // oversize length 1025
    start(); b = wr_n;
    send(8'h04); send(8'h01);
    check("t3_err", err, 1);
    check("t3_in_ready", in_ready, 0);
    check("t3_busy", busy, 0);
    check("t3_done", done, 0);
    tick();
    check("t3_nwr", wr_n - b, 0);

    // length 1024 is accepted, then reset lands on word 1 byte 4
    start(); b = wr_n;
    send(8'h04); send(8'h00);
    check("t5_err", err, 0);
    check("t5_busy", busy, 1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h88;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("t5_we", mem_we, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_done", done, 0);
    check("t5_err_rst", err, 0);
    check("t5_addr", mem_addr, 0);
    check("t5_wdata", mem_wdata, 0);
    check("t5_words", words_loaded, 0);
    tick();
    check("t5_nwr", wr_n - b, 1);
    check("t5_addr0", wr_addr[b], 0);
    check("t5_data0", wr_data[b], 32'h11223344);
    start(); b = wr_n;
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("t5_re_addr", mem_addr, 0);
    check("t5_re_data", mem_wdata, 32'hAABBCCDD);
`ifdef MIPS32_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("t5_re_done", done, 1);

    // load_start while busy is ignored
    start(); b = wr_n;
    send(8'h00);
    load_start = 1'b1;
    send(8'h01);
    load_start = 1'b0;
    check("t7_busy", busy, 1);
    check("t7_in_ready", in_ready, 1);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    check("t7_we", mem_we, 1);
    check("t7_addr", mem_addr, 0);
    check("t7_data", mem_wdata, 32'hDEADBEEF);
    check("t7_words", words_loaded, 1);
`ifdef MIPS32_LOADER_CHECKSUM_EN
    send(8'h22);
`endif
    check("t7_done", done, 1);
    tick();
    check("t7_nwr", wr_n - b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
